cla_pipe_adder: RTL

Parametrised, pipelined carry-lookahead adder. It is the successor to the fixed 16-bit combinational CLA16.
- Operand width, lookahead block size and pipeline depth are all generic.
- Adds an explicit carry-in and a valid/ready handshake on both sides.
- Sits between operand producers and consumers in datapaths where a single-cycle wide add misses timing.

---
 rtl/cla_pkg.sv | 21 ++
 rtl/cla_block.sv | 25 ++
 rtl/cla_pipe_adder.sv | 111 +++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// cla_pkg: sizing helpers, parameter legality check and the per-stage control fields
// carried with each pipeline token (CLA_PIPE_SUB_EN adds the subtract flag).
package cla_pkg;
    function automatic int seg_width(int width, int stages);
        return width / stages;
    endfunction
    function automatic int group_count(int width, int stages, int block);
        return width / stages / block;
    endfunction
    function automatic bit params_legal(int width, int block, int stages);
        return width >= 4 && stages >= 1 && block >= 1 && width % stages == 0 &&
               (width / stages) % block == 0;
    endfunction
    typedef struct packed {
        logic valid;
        logic carry;
`ifdef CLA_PIPE_SUB_EN
        logic sub;
`endif
    } cla_ctl_t;
endpackage

// File: rtl/cla_block.sv
// cla_block: combinational BLOCK-bit carry-lookahead group with group propagate/generate.
module cla_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             c_in,
    output logic [BLOCK-1:0] s,
    output logic             p,
    output logic             g
);
    logic [BLOCK-1:0] pb, gb, c;
    assign pb = a ^ b;
    assign gb = a & b;
    assign p  = &pb;
    always_comb begin
        c[0] = c_in;
        g    = gb[0];
        for (int i = 1; i < BLOCK; i++) begin
            c[i] = gb[i-1] | (pb[i-1] & c[i-1]);
            g    = gb[i] | (pb[i] & g);
        end
    end
    assign s = pb ^ c;
endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: STAGES-deep pipelined carry-lookahead adder with valid/ready handshake.
// Define CLA_PIPE_SUB_EN to add the sub input and the ovf output.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_PIPE_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int SEG_W = seg_width(WIDTH, STAGES);
    localparam int NG    = group_count(WIDTH, STAGES, BLOCK);

    typedef struct packed {
        cla_ctl_t         ctl;
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } token_t;

    token_t in_tok;
    token_t tok_q [STAGES];
    token_t tok_d [STAGES];
    logic   advance;

    if (!params_legal(WIDTH, BLOCK, STAGES)) begin : g_illegal
        $error("cla_pipe_adder: WIDTH must be >= 4 and divisible by STAGES, SEG_W by BLOCK");
    end

    always_comb begin
        in_tok           = '0;
        in_tok.ctl.valid = in_valid;
        in_tok.ctl.carry = cin;
        in_tok.a         = a;
        in_tok.b         = b;
`ifdef CLA_PIPE_SUB_EN
        // subtract is a + ~b + 1: the inversion happens per stage, the +1 enters as carry
        in_tok.ctl.sub   = sub;
        in_tok.ctl.carry = sub | cin;
`endif
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        token_t           st_in, st_out;
        logic [SEG_W-1:0] sa, sb, ss;
        logic [NG-1:0]    gp, gg;
        logic [NG:0]      gc;
        if (k == 0) begin : g_first
            assign st_in = in_tok;
        end else begin : g_next
            assign st_in = tok_q[k-1];
        end
        assign sa = st_in.a[k*SEG_W +: SEG_W];
`ifdef CLA_PIPE_SUB_EN
        assign sb = st_in.b[k*SEG_W +: SEG_W] ^ {SEG_W{st_in.ctl.sub}};
`else
        assign sb = st_in.b[k*SEG_W +: SEG_W];
`endif
        assign gc[0] = st_in.ctl.carry;
        for (genvar j = 0; j < NG; j++) begin : g_grp
            cla_block #(.BLOCK(BLOCK)) u_blk (
                .a    (sa[j*BLOCK +: BLOCK]),
                .b    (sb[j*BLOCK +: BLOCK]),
                .c_in (gc[j]),
                .s    (ss[j*BLOCK +: BLOCK]),
                .p    (gp[j]),
                .g    (gg[j])
            );
            assign gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end
        always_comb begin
            st_out                       = st_in;
            st_out.ctl.carry             = gc[NG];
            st_out.s[k*SEG_W +: SEG_W]   = ss;
        end
        assign tok_d[k] = st_out;
    end

    // one global stall: the whole pipe moves or holds together
    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++)
            if (rst) tok_q[k] <= '0;
            else if (advance) tok_q[k] <= tok_d[k];
    end

    assign out_valid = tok_q[STAGES-1].ctl.valid;
    assign sum       = tok_q[STAGES-1].s;
    assign cout      = tok_q[STAGES-1].ctl.carry;
`ifdef CLA_PIPE_SUB_EN
    assign ovf = (tok_q[STAGES-1].a[WIDTH-1] == (tok_q[STAGES-1].b[WIDTH-1] ^ tok_q[STAGES-1].ctl.sub)) &&
                 (tok_q[STAGES-1].s[WIDTH-1] != tok_q[STAGES-1].a[WIDTH-1]);
`endif
endmodule
